// File: rtl/fol_coef_sched.sv
// Coefficient scheduler for the FOL_Filter16 a0 input.
// A request is accepted from the control side. The coefficient then walks
// toward the target in bounded steps with a programmable dwell between steps.
// After the final step a settle window runs, and a done pulse ends the cycle.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ready for a request, o_a0 holds its last value
//   ST_RAMP   | stepping o_a0 toward the latched target every dwell edges
//   ST_SETTLE | target reached, counting out the settle window
module fol_coef_sched #(
  parameter int unsigned N          = 15,
  parameter logic [15:0] A0_INIT    = 16'd10000,
  parameter int unsigned SETTLE_CYC = 64
) (
  input  logic        i_clkp,
  input  logic        i_rstn,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic [15:0] i_tgt_a0,
  input  logic [15:0] i_step,
  input  logic [15:0] i_dwell,
  input  logic        i_abort,
  output logic [15:0] o_a0,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_aborted,
  output logic        o_clamp
);

  localparam logic [16:0] A0_MAX      = 17'(1) << N;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_SETTLE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a0_q, a0_d;
  logic [15:0] tgt_q, tgt_d;
  logic [15:0] step_q, step_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        clamp_q, clamp_d;

  logic        req_over;
  logic [15:0] req_tgt;
  logic        dir_up;
  logic [16:0] diff_mag;

  // Targets above 2^N are pinned to the top of the legal coefficient range.
  assign req_over = {1'b0, i_tgt_a0} > A0_MAX;
  assign req_tgt  = req_over ? A0_MAX[15:0] : i_tgt_a0;

  // Distance to target as 17-bit magnitude plus direction.
  assign dir_up   = tgt_q > a0_q;
  assign diff_mag = dir_up ? ({1'b0, tgt_q} - {1'b0, a0_q})
                           : ({1'b0, a0_q} - {1'b0, tgt_q});

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn) begin
      state_q   <= ST_IDLE;
      a0_q      <= A0_INIT;
      tgt_q     <= A0_INIT;
      step_q    <= '0;
      dwell_q   <= 16'd1;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      clamp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a0_q      <= a0_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      clamp_q   <= clamp_d;
    end
  end

  // Next-state logic: accept, ramp stepping, settle countdown, abort.
  always_comb begin
    state_d   = state_q;
    a0_d      = a0_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    clamp_d   = clamp_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_vld && rdy_q) begin
          tgt_d   = req_tgt;
          step_d  = i_step;
          dwell_d = (i_dwell == 16'd0) ? 16'd1 : i_dwell;
          clamp_d = req_over;
          cnt_d   = '0;
          if (req_tgt == a0_q) begin
            state_d = ST_SETTLE;
          end else if (i_step == 16'd0) begin
            a0_d    = req_tgt;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (i_abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q + 16'd1 == dwell_q) begin
          cnt_d = '0;
          if (diff_mag <= {1'b0, step_q}) begin
            a0_d    = tgt_q;
            state_d = ST_SETTLE;
          end else if (dir_up) begin
            a0_d = a0_q + step_q;
          end else begin
            a0_d = a0_q - step_q;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_SETTLE: begin
        if (i_abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdy_d  = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  assign o_req_rdy = rdy_q;
  assign o_a0      = a0_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_aborted = aborted_q;
  assign o_clamp   = clamp_q;

endmodule

// File: tb/tb_fol_coef_sched.sv
// Bench for fol_coef_sched: directed scenarios, a behavioural reference model
// compared every cycle, and hand-computed checkpoints.
module tb_fol_coef_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vld;
  logic        rdy;
  logic [15:0] tgt;
  logic [15:0] stp;
  logic [15:0] dwl;
  logic        abrt;
  logic [15:0] a0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        clamp;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fol_coef_sched #(.N(15), .A0_INIT(16'd10000), .SETTLE_CYC(64)) dut (
    .i_clkp    (clk),
    .i_rstn    (rstn),
    .i_req_vld (vld),
    .o_req_rdy (rdy),
    .i_tgt_a0  (tgt),
    .i_step    (stp),
    .i_dwell   (dwl),
    .i_abort   (abrt),
    .o_a0      (a0),
    .o_busy    (busy),
    .o_done    (done),
    .o_aborted (aborted),
    .o_clamp   (clamp)
  );

  // Reference model: mode 0 idle, 1 ramping, 2 settling.
  int m_mode = 0;
  int m_a0 = 10000;
  int m_tgt = 10000;
  int m_step = 0;
  int m_dwell = 1;
  int m_wait = 0;
  int m_left = 0;
  int m_rdy = 0;
  int m_busy = 0;
  int m_done = 0;
  int m_ab = 0;
  int m_clamp = 0;

  always @(posedge clk) begin
    int diff;
    int mag;
    if (!rstn) begin
      m_mode = 0; m_a0 = 10000; m_rdy = 0; m_busy = 0;
      m_done = 0; m_ab = 0; m_clamp = 0;
    end else begin
      m_done = 0;
      m_ab = 0;
      if (m_mode == 0) begin
        if (vld && m_rdy == 1) begin
          m_tgt   = (int'(tgt) > 32768) ? 32768 : int'(tgt);
          m_clamp = (int'(tgt) > 32768) ? 1 : 0;
          m_step  = int'(stp);
          m_dwell = (dwl == 0) ? 1 : int'(dwl);
          if (m_tgt == m_a0) begin
            m_mode = 2; m_left = 64;
          end else if (m_step == 0) begin
            m_a0 = m_tgt; m_mode = 2; m_left = 64;
          end else begin
            m_mode = 1; m_wait = m_dwell;
          end
        end
      end else if (abrt) begin
        m_mode = 0; m_ab = 1;
      end else if (m_mode == 1) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          diff = m_tgt - m_a0;
          mag  = (diff < 0) ? -diff : diff;
          if (mag <= m_step) begin
            m_a0 = m_tgt; m_mode = 2; m_left = 64;
          end else begin
            m_a0 = (diff > 0) ? m_a0 + m_step : m_a0 - m_step;
          end
          m_wait = m_dwell;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1; m_mode = 0;
        end
      end
      m_rdy  = (m_mode == 0) ? 1 : 0;
      m_busy = (m_mode != 0) ? 1 : 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_a0", int'(a0), m_a0);
      chk("cyc_rdy", int'(rdy), m_rdy);
      chk("cyc_busy", int'(busy), m_busy);
      chk("cyc_done", int'(done), m_done);
      chk("cyc_aborted", int'(aborted), m_ab);
      chk("cyc_clamp", int'(clamp), m_clamp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge (the accept edge when ready is high).
  task automatic req(input int t, input int s, input int d);
    vld = 1'b1;
    tgt = 16'(t);
    stp = 16'(s);
    dwl = 16'(d);
    tick(1);
    vld = 1'b0;
    tgt = 16'hFFFF;
    stp = 16'h0001;
    dwl = 16'h0007;
  endtask

  initial begin
    rstn = 1'b0; vld = 1'b0; tgt = '0; stp = '0; dwl = '0; abrt = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("rst_a0", int'(a0), 10000);
    chk("rst_rdy", int'(rdy), 0);
    chk("rst_busy", int'(busy), 0);
    rstn = 1'b1;
    tick(1);
    chk("rdy_after_rst", int'(rdy), 1);

    // Up ramp 10000 -> 11000, step 100, dwell 4.
    req(11000, 100, 4);
    chk("up_accept_busy", int'(busy), 1);
    chk("up_accept_rdy", int'(rdy), 0);
    tick(3);
    chk("up_t3", int'(a0), 10000);
    tick(1);
    chk("up_t4", int'(a0), 10100);
    chk("model_up_t4", m_a0, 10100);
    tick(16);
    chk("up_t20", int'(a0), 10500);
    tick(20);
    chk("up_t40", int'(a0), 11000);
    tick(63);
    chk("up_t103_done", int'(done), 0);
    chk("up_t103_busy", int'(busy), 1);
    tick(1);
    chk("up_t104_done", int'(done), 1);
    chk("up_t104_busy", int'(busy), 0);
    chk("up_t104_rdy", int'(rdy), 1);
    tick(1);
    chk("up_done_pulse", int'(done), 0);

    // Non-divisible down ramp, dwell 0 behaves as 1.
    req(10050, 300, 0);
    chk("dn_accept", int'(a0), 11000);
    tick(1); chk("dn_1", int'(a0), 10700);
    tick(1); chk("dn_2", int'(a0), 10400);
    tick(1); chk("dn_3", int'(a0), 10100);
    tick(1); chk("dn_4", int'(a0), 10050);
    chk("model_dn_4", m_a0, 10050);
    tick(63); chk("dn_done_early", int'(done), 0);
    tick(1);  chk("dn_done", int'(done), 1);
    tick(1);

    // Clamped immediate jump, then a following accept clears the clamp flag.
    req(40000, 0, 5);
    chk("clamp_a0", int'(a0), 32768);
    chk("clamp_flag", int'(clamp), 1);
    tick(64);
    chk("clamp_done", int'(done), 1);
    chk("clamp_sticky", int'(clamp), 1);
    tick(1);
    req(5000, 0, 0);
    chk("jump_a0", int'(a0), 5000);
    chk("clamp_cleared", int'(clamp), 0);
    tick(64);
    chk("jump_done", int'(done), 1);
    tick(1);

    // Abort on the same edge as the third step.
    rstn = 1'b0; tick(1); rstn = 1'b1; tick(1);
    chk("abort_start_a0", int'(a0), 10000);
    req(12000, 100, 4);
    tick(8);
    chk("abort_pre", int'(a0), 10200);
    tick(3);
    abrt = 1'b1; tick(1); abrt = 1'b0;
    chk("abort_hold_a0", int'(a0), 10200);
    chk("abort_pulse", int'(aborted), 1);
    chk("abort_rdy", int'(rdy), 1);
    chk("abort_busy", int'(busy), 0);
    tick(1);
    chk("abort_pulse_end", int'(aborted), 0);

    // Abort during settle.
    req(12000, 0, 0);
    tick(10);
    abrt = 1'b1; tick(1); abrt = 1'b0;
    chk("abort_settle_a0", int'(a0), 12000);
    chk("abort_settle_pulse", int'(aborted), 1);
    tick(70);
    chk("abort_settle_nodone", int'(done), 0);

    // Abort in idle is ignored and a simultaneous request is accepted.
    abrt = 1'b1;
    req(12500, 0, 0);
    abrt = 1'b0;
    chk("idle_abort_a0", int'(a0), 12500);
    chk("idle_abort_busy", int'(busy), 1);
    chk("idle_abort_nopulse", int'(aborted), 0);
    tick(64);
    chk("idle_abort_done", int'(done), 1);

    // Reset in the middle of a ramp.
    req(13000, 100, 2);
    tick(5);
    rstn = 1'b0; tick(1);
    chk("midrst_a0", int'(a0), 10000);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_aborted", int'(aborted), 0);
    rstn = 1'b1; tick(1);
    chk("midrst_rdy", int'(rdy), 1);

    // Request valid held high across two transactions.
    vld = 1'b1; tgt = 16'd10300; stp = 16'd100; dwl = 16'd1;
    tick(1);
    chk("b2b_busy", int'(busy), 1);
    tick(3);
    chk("b2b_a0", int'(a0), 10300);
    tick(63);
    chk("b2b_busy_hold", int'(busy), 1);
    tick(1);
    chk("b2b_done", int'(done), 1);
    chk("b2b_rdy", int'(rdy), 1);
    tick(1);
    chk("b2b_reaccept_busy", int'(busy), 1);
    chk("b2b_reaccept_rdy", int'(rdy), 0);
    chk("b2b_reaccept_done", int'(done), 0);
    tick(63);
    chk("b2b2_early", int'(done), 0);
    tick(1);
    chk("b2b2_done", int'(done), 1);
    vld = 1'b0;
    tick(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
